// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: mode encodings, FSM states
// and the shift-mode classifier used by both the burst and single-step paths.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } usr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } usr_state_e;

    // Only these modes move bits through so and may run as a burst.
    function automatic logic is_shift_mode(input usr_mode_e m);
        return (m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});
    endfunction

endpackage

// File: rtl/usr_step.sv
// One step of the shift register datapath: next contents and the bit that
// leaves the register. Purely combinational; LOAD/HOLD report out_bit as 0.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_po,
    input  usr_mode_e        i_mode,
    input  logic             i_si_l,
    input  logic             i_si_r,
    input  logic [WIDTH-1:0] i_pi,
    output logic [WIDTH-1:0] o_next_po,
    output logic             o_out_bit
);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        o_next_po = i_po;
        o_out_bit = 1'b0;
        case (i_mode)
            MODE_SHL: begin
                o_next_po = {i_po[WIDTH-2:0], i_si_r};
                o_out_bit = i_po[WIDTH-1];
            end
            MODE_SHR: begin
                o_next_po = {i_si_l, i_po[WIDTH-1:1]};
                o_out_bit = i_po[0];
            end
            MODE_ROL: begin
                o_next_po = {i_po[WIDTH-2:0], i_po[WIDTH-1]};
                o_out_bit = i_po[WIDTH-1];
            end
            MODE_ROR: begin
                o_next_po = {i_po[0], i_po[WIDTH-1:1]};
                o_out_bit = i_po[0];
            end
            MODE_ASR: begin
                o_next_po = {i_po[WIDTH-1], i_po[WIDTH-1:1]};
                o_out_bit = i_po[0];
            end
            MODE_LOAD: o_next_po = i_pi;
            default:   o_next_po = i_po;
        endcase
    end

endmodule

// File: rtl/usr_param.sv
// Universal shift register with single-step ops and a start/amt burst engine.
// Define USR_PARAM_ABORT_EN to add the abort input and the aborted pulse.
module usr_param
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
`ifdef USR_PARAM_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] pi,
    input  logic             si_r,
    input  logic             si_l,
    output logic [WIDTH-1:0] po,
    output logic             so,
    output logic             busy,
    output logic             done
);

    usr_state_e       r_state, w_state_nx;
    usr_mode_e        r_mode_q, w_mode_in, w_step_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_po, w_next_po;
    logic             r_so, r_done;
    logic             w_out_bit, w_start_ok, w_last, w_abort;
    logic             w_accept, w_do_step, w_done_nx;

    assign w_mode_in   = usr_mode_e'(mode);
    assign w_start_ok  = start && is_shift_mode(w_mode_in) && (amt != '0);
    assign w_last      = (r_cnt == CNT_W'(1));
    assign w_step_mode = (r_state == BURST) ? r_mode_q : w_mode_in;

`ifdef USR_PARAM_ABORT_EN
    logic r_aborted;

    always_ff @(posedge clk) begin
        if (rst) r_aborted <= 1'b0;
        else     r_aborted <= (r_state == BURST) && abort;
    end

    assign w_abort = abort;
    assign aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    usr_step #(.WIDTH(WIDTH)) u_step (
        .i_po      (r_po),
        .i_mode    (w_step_mode),
        .i_si_l    (si_l),
        .i_si_r    (si_r),
        .i_pi      (pi),
        .o_next_po (w_next_po),
        .o_out_bit (w_out_bit)
    );

    // NOTE: reset is synchronous and outranks every other condition, including a live burst.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nx = BURST;
            BURST:   if (w_abort || w_last) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_accept  = 1'b0;
        w_do_step = 1'b0;
        w_done_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_accept  = 1'b1;
                else if (en)    w_do_step = 1'b1;
            end
            BURST: begin
                if (!w_abort) begin
                    w_do_step = 1'b1;
                    w_done_nx = w_last;
                end
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_po     <= '0;
            r_so     <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_mode_q <= MODE_HOLD;
        end else begin
            r_done <= w_done_nx;
            if (w_accept) begin
                r_mode_q <= w_mode_in;
                r_cnt    <= amt;
            end else if ((r_state == BURST) && w_do_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_do_step) begin
                r_po <= w_next_po;
                if (is_shift_mode(w_step_mode)) r_so <= w_out_bit;
            end
        end
    end

    assign po   = r_po;
    assign so   = r_so;
    assign busy = (r_state == BURST);
    assign done = r_done;

endmodule

// File: tb/tb_usr_param.sv
// Self-checking bench for usr_param: scoreboard of expected po/so per step,
// plus fixed-value checks on the documented scenarios.
module tb_usr_param;
    import usr_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct packed {
        logic [W-1:0] po;
        logic         so;
    } exp_t;

    logic          clk, rst, en, start;
    logic [2:0]    mode;
    logic [CW-1:0] amt;
    logic [W-1:0]  pi, po;
    logic          si_r, si_l, so, busy, done;
`ifdef USR_PARAM_ABORT_EN
    logic          abort, aborted;
`endif

    exp_t sb[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;

    usr_param #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
`ifdef USR_PARAM_ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .mode  (mode),
        .amt   (amt),
        .pi    (pi),
        .si_r  (si_r),
        .si_l  (si_l),
        .po    (po),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model_step(input exp_t c, input logic [2:0] m,
                                        input logic [W-1:0] p_in, input logic sl, input logic sr);
        exp_t nx = c;
        case (m)
            3'b001: begin nx.po = (c.po << 1) | W'(sr);            nx.so = c.po[W-1]; end
            3'b010: begin nx.po = (c.po >> 1) | (W'(sl) << (W-1)); nx.so = c.po[0];   end
            3'b011: nx.po = p_in;
            3'b100: begin nx.po = (c.po << 1) | (c.po >> (W-1));   nx.so = c.po[W-1]; end
            3'b101: begin nx.po = (c.po >> 1) | (c.po << (W-1));   nx.so = c.po[0];   end
            3'b110: begin nx.po = W'($signed(c.po) >>> 1);         nx.so = c.po[0];   end
            default: nx = c;
        endcase
        return nx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        en = 1'b0; start = 1'b0; mode = MODE_HOLD; amt = '0;
        pi = '0; si_r = 1'b0; si_l = 1'b0;
`ifdef USR_PARAM_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    // Single en-strobed step; expectation is queued before the edge, checked after.
    task automatic apply_step(input logic [2:0] m, input logic [W-1:0] p,
                              input logic sl, input logic sr, input string name);
        exp_t e;
        mode = m; pi = p; si_l = sl; si_r = sr; en = 1'b1;
        cur = model_step(cur, m, p, sl, sr);
        sb.push_back(cur);
        tick();
        en = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (po !== e.po || so !== e.so) begin
            n_err++;
            $display("FAIL %s: got po=%h so=%b expected po=%h so=%b", name, po, so, e.po, e.so);
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s_flags: got busy=%b done=%b expected 0 0", name, busy, done);
        end
    endtask

    // Burst of a steps; ends at +1 after the completing edge (the done cycle).
    task automatic do_burst(input logic [2:0] m, input int a, input string name);
        exp_t e;
        logic [W-1:0] po0;
        logic eb, ed;
        po0 = cur.po;
        for (int i = 0; i < a; i++) begin
            cur = model_step(cur, m, '0, si_l, si_r);
            sb.push_back(cur);
        end
        mode = m; amt = CW'(a); start = 1'b1; en = 1'b0;
        tick();
        start = 1'b0; mode = MODE_LOAD; pi = '1; en = 1'b1; amt = '0;
        n_vec++;
        if (busy !== 1'b1 || po !== po0) begin
            n_err++;
            $display("FAIL %s_accept: got busy=%b po=%h expected busy=1 po=%h", name, busy, po, po0);
        end
        for (int i = 0; i < a; i++) begin
            tick();
            e  = sb.pop_front();
            eb = (i < a - 1);
            ed = (i == a - 1);
            n_vec++;
            if (po !== e.po || so !== e.so || busy !== eb || done !== ed) begin
                n_err++;
                $display("FAIL %s_step%0d: got po=%h so=%b busy=%b done=%b expected po=%h so=%b busy=%b done=%b",
                         name, i, po, so, busy, done, e.po, e.so, eb, ed);
            end
        end
        en = 1'b0; mode = MODE_HOLD; pi = '0;
    endtask

    task automatic test_reset();
        en = 1'b1; start = 1'b1; mode = 3'($urandom); amt = CW'($urandom);
        pi = W'($urandom); si_r = 1'b1; si_l = 1'b1;
`ifdef USR_PARAM_ABORT_EN
        abort = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive_idle();
        cur = '0;
        n_vec++;
        if (po !== 8'h00 || so !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got po=%h so=%b busy=%b done=%b expected 00 0 0 0", po, so, busy, done);
        end
    endtask

    task automatic test_load_shl();
        apply_step(MODE_LOAD, 8'hA5, 1'b0, 1'b0, "load_a5");
        n_vec++;
        if (po !== 8'hA5) begin n_err++; $display("FAIL load_const: got %h expected a5", po); end
        apply_step(MODE_SHL, 8'h00, 1'b0, 1'b1, "shl");
        n_vec++;
        if (po !== 8'h4B || so !== 1'b1) begin
            n_err++; $display("FAIL shl_const: got po=%h so=%b expected 4b 1", po, so);
        end
        apply_step(MODE_SHR, 8'h00, 1'b1, 1'b0, "shr");
    endtask

    task automatic test_asr_rol();
        apply_step(MODE_LOAD, 8'h90, 1'b0, 1'b0, "load_90");
        apply_step(MODE_ASR, 8'h00, 1'b0, 1'b0, "asr");
        n_vec++;
        if (po !== 8'hC8 || so !== 1'b0) begin
            n_err++; $display("FAIL asr_const: got po=%h so=%b expected c8 0", po, so);
        end
        apply_step(MODE_ROL, 8'h00, 1'b0, 1'b0, "rol");
        n_vec++;
        if (po !== 8'h91 || so !== 1'b1) begin
            n_err++; $display("FAIL rol_const: got po=%h so=%b expected 91 1", po, so);
        end
        apply_step(MODE_ROR, 8'h00, 1'b0, 1'b0, "ror");
        apply_step(MODE_HOLD, 8'hFF, 1'b1, 1'b1, "hold");
        apply_step(MODE_RSVD, 8'hFF, 1'b1, 1'b1, "reserved");
        apply_step(MODE_LOAD, 8'h5A, 1'b0, 1'b0, "load_keeps_so");
    endtask

    task automatic test_start_ignored();
        start = 1'b1; amt = '0;
        apply_step(MODE_SHL, 8'h00, 1'b0, 1'b1, "start_amt0");
        amt = CW'(3);
        apply_step(MODE_LOAD, 8'h3C, 1'b0, 1'b0, "start_load");
        en = 1'b0; mode = MODE_HOLD;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || po !== cur.po) begin
            n_err++; $display("FAIL start_hold: got busy=%b po=%h expected 0 %h", busy, po, cur.po);
        end
    endtask

    task automatic test_burst_ror();
        apply_step(MODE_LOAD, 8'h81, 1'b0, 1'b0, "load_81");
        do_burst(MODE_ROR, 3, "burst_ror");
        n_vec++;
        if (po !== 8'h30 || so !== 1'b0) begin
            n_err++; $display("FAIL burst_ror_final: got po=%h so=%b expected 30 0", po, so);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || po !== 8'h30) begin
            n_err++; $display("FAIL burst_ror_after: got done=%b busy=%b po=%h expected 0 0 30", done, busy, po);
        end
    endtask

    task automatic test_back_to_back();
        apply_step(MODE_LOAD, 8'h01, 1'b0, 1'b0, "load_01");
        do_burst(MODE_ROL, 9, "burst_rol9");
        n_vec++;
        if (po !== 8'h02) begin n_err++; $display("FAIL rol9_wrap: got %h expected 02", po); end
        si_l = 1'b1;
        do_burst(MODE_SHR, 2, "b2b_shr");
        n_vec++;
        if (po !== 8'hC0 || so !== 1'b1) begin
            n_err++; $display("FAIL b2b_final: got po=%h so=%b expected c0 1", po, so);
        end
        si_l = 1'b0;
        tick();
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_reset_mid_burst();
        apply_step(MODE_LOAD, 8'hFF, 1'b0, 1'b0, "load_ff");
        si_r = 1'b0; mode = MODE_SHL; amt = CW'(6); start = 1'b1;
        tick();
        start = 1'b0; mode = MODE_HOLD; amt = '0;
        tick();
        tick();
        n_vec++;
        if (po !== 8'hFC || busy !== 1'b1) begin
            n_err++; $display("FAIL mid_burst: got po=%h busy=%b expected fc 1", po, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur = '0;
        n_vec++;
        if (po !== 8'h00 || so !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got po=%h so=%b busy=%b done=%b expected 00 0 0 0", po, so, busy, done);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_nodone: got done=%b busy=%b expected 0 0", done, busy);
        end
        apply_step(MODE_LOAD, 8'h3C, 1'b0, 1'b0, "load_3c");
        do_burst(MODE_ASR, 2, "post_reset_asr");
        n_vec++;
        if (po !== 8'h0F || so !== 1'b0) begin
            n_err++; $display("FAIL post_reset_final: got po=%h so=%b expected 0f 0", po, so);
        end
        tick();
    endtask

`ifdef USR_PARAM_ABORT_EN
    task automatic test_abort();
        apply_step(MODE_LOAD, 8'hF0, 1'b0, 1'b0, "load_f0");
        si_l = 1'b0; mode = MODE_SHR; amt = CW'(5); start = 1'b1;
        tick();
        start = 1'b0; mode = MODE_HOLD; amt = '0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if (po !== 8'h3C || busy !== 1'b0 || aborted !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL abort: got po=%h busy=%b aborted=%b done=%b expected 3c 0 1 0", po, busy, aborted, done);
        end
        tick();
        n_vec++;
        if (aborted !== 1'b0 || done !== 1'b0 || po !== 8'h3C) begin
            n_err++; $display("FAIL abort_after: got aborted=%b done=%b po=%h expected 0 0 3c", aborted, done, po);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if (aborted !== 1'b0) begin n_err++; $display("FAIL abort_idle: got %b expected 0", aborted); end
        cur.po = 8'h3C;
        cur.so = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0;
        drive_idle();
        cur = '0;
        test_reset();
        test_load_shl();
        test_asr_rol();
        test_start_ignored();
        test_burst_ror();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef USR_PARAM_ABORT_EN
        test_abort();
`endif
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usr_param.md
Name: usr_param

Overview:
- Parametrised universal shift register: generic WIDTH, rotate and arithmetic-shift modes, registered serial-out, and a multi-cycle burst shift engine with busy/done handshake.
- Serves as the shift/serialisation datapath element for serialisers, CRC pre-conditioning and bit-banged peripheral engines.
- Single-step operations use en; N-step shifts use start and amt, with no external cycle counting.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1), width of the burst amount/counter. Derived; not overridden.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  single-step operation strobe, honoured in IDLE only
- start  input  1  burst request, honoured in IDLE only
- mode  input  3  000 HOLD, 001 SHL, 010 SHR, 011 LOAD, 100 ROL, 101 ROR, 110 ASR, 111 reserved (acts as HOLD)
- amt  input  CNT_W  burst shift count, sampled with start
- pi  input  WIDTH  parallel load data
- si_r  input  1  serial in, enters bit 0 on SHL
- si_l  input  1  serial in, enters bit WIDTH-1 on SHR
- po  output  WIDTH  register contents
- so  output  1  last bit shifted or rotated out, registered
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse on burst completion

Behaviour:
- Reset: po=0, so=0, busy=0, done=0, FSM=IDLE. Reset has priority over everything, including a burst in progress.
- One step per mode:
  - SHL: {po[W-2:0], si_r}; so <= po[W-1].
  - SHR: {si_l, po[W-1:1]}; so <= po[0].
  - ROL: {po[W-2:0], po[W-1]}; so <= po[W-1].
  - ROR: {po[0], po[W-1:1]}; so <= po[0].
  - ASR: {po[W-1], po[W-1:1]}; so <= po[0].
  - LOAD: po <= pi; so unchanged.
  - HOLD/111: nothing changes.
- Shift modes are SHL, SHR, ROL, ROR and ASR.
- IDLE, start=1, shift mode, amt!=0:
  - Latch mode into mode_q and amt into cnt; go to BURST.
  - busy=1 from this edge. No shift occurs on this edge.
- IDLE, start=1 with amt==0 or a non-shift mode: start is ignored and the en rules apply.
- IDLE, en=1, start not accepted: one step of mode on this edge. done stays 0.
- BURST: one step of mode_q per edge, cnt decrements.
  - mode, start, en and amt inputs are ignored.
  - si_l and si_r are sampled live each cycle.
  - On the edge where cnt==1: perform the last shift, go to IDLE, busy<=0, done<=1 for exactly one cycle.
- Latency: a burst of N gives N shifts on edges k+1..k+N after start is sampled at edge k. busy is high from k to k+N; done is high in the cycle after edge k+N.
- Back-to-back: start is accepted in the cycle where done=1.
- amt > WIDTH is legal. The register shifts amt times, so rotates wrap modulo WIDTH.
- Reset mid-burst: immediate IDLE, po=0, no done pulse.

Optional Feature:
- Macro USR_PARAM_ABORT_EN.
- Defined:
  - Adds input abort (1b) and output aborted (1b pulse).
  - abort=1 in BURST: at the next edge go to IDLE with no shift on that edge; po and so keep their partially shifted values; busy<=0; aborted<=1 for one cycle; done stays 0.
  - abort in IDLE is ignored.
  - If abort and cnt==1 coincide, abort wins.
- Undefined: neither port exists and behaviour is as above.

Decomposition:
- Package usr_pkg:
  - usr_mode_e, a 3-bit enum of the mode encodings.
  - usr_state_e {IDLE, BURST}.
  - function is_shift_mode(usr_mode_e).
- Sub-module usr_step: purely combinational (po, mode, si_l, si_r, pi) -> (next_po, out_bit). Shared by the single-step and burst paths.
- Top level holds the FSM, counter and registers.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary inputs -> po=8'h00, so=0, busy=0, done=0.
- LOAD then SHL: mode=011, pi=8'hA5, en=1 -> po=8'hA5. Then mode=001, si_r=1, en=1 -> po=8'h4B, so=1.
- ASR: load 8'h90, then mode=110, en=1 -> po=8'hC8, so=0. A further ROL step -> po=8'h91, so=1.
- Burst ROR: load 8'h81, start=1, mode=101, amt=3.
  - busy high for 3 cycles; po goes C0, 60, 30.
  - done is a one-cycle pulse, final so=0.
  - en pulses during busy have no effect.
- Reset mid-burst: start SHL amt=6 from 8'hFF, assert rst after 2 shifts -> po=8'h00, busy=0, no done pulse. A new start is accepted afterwards.
- With USR_PARAM_ABORT_EN: burst SHR amt=5, si_l=0 from 8'hF0, abort after 2 shifts -> po=8'h3C, aborted pulses once, done stays 0.
